cdc_2_phase_rx: RTL and testbench

//   Receive-side endpoint of the 2-phase (toggle) req/ack handshake, in the destination clock domain.

---
 rtl/cdc_2_phase_rx.sv | 79 +++++++
 tb/tb_cdc_2_phase_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_2_phase_rx.sv
// Receive endpoint of a 2-phase (toggle) req/ack handshake in the destination clock domain.
// Synchronises the request, captures bundled data, and presents it on a valid/ready stream.
module cdc_2_phase_rx #(
    parameter int G_STAGES    = 2,
    parameter int G_WIDTH     = 4,
    parameter int G_CNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req,
    input  logic [G_WIDTH-1:0]     i_data,
    output logic                   o_ack,
    output logic                   o_valid,
    output logic [G_WIDTH-1:0]     o_data,
    input  logic                   i_ready,
    output logic [G_CNT_WIDTH-1:0] o_xfer_count,
    output logic                   o_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t              state;
    logic [G_STAGES-1:0] req_sync;
    logic                req_s;
    logic                req_s_d;
    logic                pending;

    assign req_s   = req_sync[G_STAGES-1];
    assign pending = req_s ^ o_ack;

    // i_req is only ever sampled here; everything downstream sees req_s
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[G_STAGES-2:0], i_req};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_ack        <= 1'b0;
            o_xfer_count <= '0;
            o_overrun    <= 1'b0;
            req_s_d      <= 1'b0;
        end else begin
            req_s_d <= req_s;
            case (state)
                IDLE: begin
                    if (pending) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                        state   <= VALID;
                    end
                end
                VALID: begin
                    // sender toggled again before we acknowledged: protocol violation
                    if (req_s != req_s_d) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_ready) begin
                        o_valid      <= 1'b0;
                        o_ack        <= ~o_ack;
                        o_xfer_count <= o_xfer_count + G_CNT_WIDTH'(1);
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_2_phase_rx.sv
// Bench for cdc_2_phase_rx: toggle sender model, random downstream backpressure,
// and a queue-based reference of words sent, words accepted and transfer count.
module tb_cdc_2_phase_rx;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_req;
    logic [3:0] i_data;
    logic       i_ready;

    logic       o_ack;
    logic       o_valid;
    logic [3:0] o_data;
    logic [7:0] o_xfer_count;
    logic       o_overrun;

    logic       ack2;
    logic       valid2;
    logic [3:0] data2;
    logic [1:0] count2;
    logic       ovr2;

    int          errors;
    int          checks;
    logic [31:0] acc_cnt;
    logic        exp_ovr;
    logic [3:0]  exp_q[$];

    cdc_2_phase_rx #(.G_STAGES(2), .G_WIDTH(4), .G_CNT_WIDTH(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_data       (i_data),
        .o_ack        (o_ack),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready),
        .o_xfer_count (o_xfer_count),
        .o_overrun    (o_overrun)
    );

    cdc_2_phase_rx #(.G_STAGES(2), .G_WIDTH(4), .G_CNT_WIDTH(2)) dut_c2 (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_data       (i_data),
        .o_ack        (ack2),
        .o_valid      (valid2),
        .o_data       (data2),
        .i_ready      (i_ready),
        .o_xfer_count (count2),
        .o_overrun    (ovr2)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        i_ready = 1'b0;
        i_data  = 4'h0;
        acc_cnt = 0;
        exp_ovr = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bit seen;
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        i_ready = 1'b0;
        i_data  = 4'h0;
        #1;
        checks++; if (o_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", o_ack); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_data); end
        checks++; if (o_xfer_count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h expected 0", o_xfer_count); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", o_overrun); end
        tick();
        i_rst_n = 1'b1;
        tick();
        // get a word into VALID, then reset between clock edges
        i_data = 4'h5;
        i_req  = 1'b1;
        seen   = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = (o_valid === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL reset_midxfer_valid: got %b expected 1", o_valid); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %b expected 0", o_valid); end
        checks++; if (o_data !== 4'h0) begin errors++; $display("FAIL reset_async_data: got %h expected 0", o_data); end
        i_req = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        do_reset();
        i_data  = 4'hA;
        i_ready = 1'b1;
        i_req   = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1_valid: got %b expected 0", o_valid); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_edge2_valid: got %b expected 0", o_valid); end
        tick();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL lat_edge3_valid: got %b expected 1", o_valid); end
        checks++; if (o_data !== 4'hA) begin errors++; $display("FAIL lat_edge3_data: got %h expected a", o_data); end
        tick();
        acc_cnt++;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_edge4_valid: got %b expected 0", o_valid); end
        checks++; if (o_ack !== 1'b1) begin errors++; $display("FAIL lat_edge4_ack: got %b expected 1", o_ack); end
        checks++; if (o_xfer_count !== 8'd1) begin errors++; $display("FAIL lat_edge4_count: got %0d expected 1", o_xfer_count); end
        i_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] w;
        bit         seen;
        w       = 4'($urandom);
        i_ready = 1'b0;
        i_data  = w;
        i_req   = ~i_req;
        seen    = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = (o_valid === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_valid_timeout: got %b expected 1", o_valid); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", o_valid); end
            checks++; if (o_data !== w) begin errors++; $display("FAIL bp_hold_data: got %h expected %h", o_data, w); end
            checks++; if (o_ack !== acc_cnt[0]) begin errors++; $display("FAIL bp_hold_ack: got %b expected %b", o_ack, acc_cnt[0]); end
        end
        i_ready = 1'b1;
        tick();
        acc_cnt++;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_valid: got %b expected 0", o_valid); end
        checks++; if (o_ack !== acc_cnt[0]) begin errors++; $display("FAIL bp_accept_ack: got %b expected %b", o_ack, acc_cnt[0]); end
        checks++; if (o_xfer_count !== acc_cnt[7:0]) begin errors++; $display("FAIL bp_accept_count: got %0d expected %0d", o_xfer_count, acc_cnt[7:0]); end
        i_ready = 1'b0;
    endtask

    // sender sends n words (1..n or random), downstream accepts with random ready
    task automatic xfer_words(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            logic [3:0] w;
            logic [3:0] d;
            logic [3:0] e;
            logic       v;
            bit         done;
            w = seq ? 4'(i + 1) : 4'($urandom);
            i_data = w;
            i_req  = ~i_req;
            exp_q.push_back(w);
            done = 1'b0;
            for (int c = 0; c < 80 && !done; c++) begin
                i_ready = ($urandom_range(0, 2) != 0);
                v = o_valid;
                d = o_data;
                tick();
                if (v === 1'b1 && i_ready === 1'b1) begin
                    e = exp_q.pop_front();
                    acc_cnt++;
                    done = 1'b1;
                    checks++; if (d !== e) begin errors++; $display("FAIL xfer_data: got %h expected %h", d, e); end
                    checks++; if (o_ack !== acc_cnt[0]) begin errors++; $display("FAIL xfer_ack: got %b expected %b", o_ack, acc_cnt[0]); end
                    checks++; if (o_xfer_count !== acc_cnt[7:0]) begin errors++; $display("FAIL xfer_count8: got %0d expected %0d", o_xfer_count, acc_cnt[7:0]); end
                    checks++; if (count2 !== acc_cnt[1:0]) begin errors++; $display("FAIL xfer_count2: got %0d expected %0d", count2, acc_cnt[1:0]); end
                    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL xfer_idle_after: got %b expected 0", o_valid); end
                    checks++; if (o_overrun !== exp_ovr) begin errors++; $display("FAIL xfer_overrun: got %b expected %b", o_overrun, exp_ovr); end
                end
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL xfer_timeout: got no acceptance expected word %h", w);
                exp_q.delete();
            end
            // after the ack the sender may change data freely; no second capture allowed
            i_data  = 4'($urandom);
            i_ready = 1'b1;
            for (int c = 0; c < 2; c++) begin
                tick();
                checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL xfer_duplicate: got %b expected 0", o_valid); end
            end
        end
        i_ready = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        xfer_words(4, 1'b1);
        checks++; if (o_ack !== 1'b0) begin errors++; $display("FAIL stream_final_ack: got %b expected 0", o_ack); end
        checks++; if (o_xfer_count !== 8'd4) begin errors++; $display("FAIL stream_final_count: got %0d expected 4", o_xfer_count); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL stream_no_overrun: got %b expected 0", o_overrun); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        xfer_words(5, 1'b0);
        checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL wrap_final_count2: got %0d expected 1", count2); end
    endtask

    task automatic test_overrun();
        logic [3:0] w;
        bit         seen;
        do_reset();
        w       = 4'h9;
        i_ready = 1'b0;
        i_data  = w;
        i_req   = ~i_req;
        seen    = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = (o_valid === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL ovr_valid_timeout: got %b expected 1", o_valid); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clean_before: got %b expected 0", o_overrun); end
        i_req = ~i_req;
        repeat (3) tick();
        i_req = ~i_req;
        repeat (4) tick();
        exp_ovr = 1'b1;
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", o_overrun); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ovr_still_valid: got %b expected 1", o_valid); end
        checks++; if (o_data !== w) begin errors++; $display("FAIL ovr_data_held: got %h expected %h", o_data, w); end
        i_ready = 1'b1;
        tick();
        acc_cnt++;
        checks++; if (o_ack !== acc_cnt[0]) begin errors++; $display("FAIL ovr_accept_ack: got %b expected %b", o_ack, acc_cnt[0]); end
        i_ready = 1'b0;
        tick();
        xfer_words(3, 1'b0);
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", o_overrun); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        acc_cnt = 0;
        exp_ovr = 1'b0;
        i_rst_n = 1'b0;
        i_req = 1'b0;
        i_ready = 1'b0;
        i_data = 4'h0;
        test_reset();
        test_latency();
        test_backpressure();
        test_stream();
        test_count_wrap();
        do_reset();
        xfer_words(20, 1'b0);
        test_backpressure();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
